// File: rtl/alu_exec_stage.sv
// Execute stage: operand register feeding an external ALU, then a 2-entry result buffer toward writeback.
// Latency: 2 cycles from accept to out_valid (OR stage, then RB stage).
// Backpressure: in_ready drops once the RB is full and the OR is occupied; a same-cycle pop frees a slot.

// Small synchronous FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_vld,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_rdy,
  output logic [W-1:0]  rd_dat,
  output logic [CW-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_vld) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_rdy) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // Simultaneous write and read leaves the occupancy unchanged.
      case ({wr_vld, rd_rdy})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rd_dat = mem[rd_ptr];
  assign count  = cnt;
endmodule

module alu_exec_stage #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [3:0]       in_ALUop,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_ALUop,
  input  logic [31:0]      alu_result,
  input  logic             alu_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_flag,
  output logic [TAG_W-1:0] out_tag,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  output logic [15:0]      op_count
);
  localparam int RB_W = 32 + 1 + TAG_W;

  logic             or_vld;
  logic [31:0]      or_a;
  logic [31:0]      or_b;
  logic [3:0]       or_op;
  logic [TAG_W-1:0] or_tag;

  logic [1:0]       rb_cnt;
  logic [RB_W-1:0]  rb_wr_dat;
  logic [RB_W-1:0]  rb_rd_dat;
  logic             wr_flag;
  logic             pop;
  logic             xfer;
  logic             accept;

  assign out_valid = (rb_cnt != 2'd0);
  assign pop       = out_valid & out_ready;
  // out_ready -> pop -> xfer -> in_ready is a deliberate combinational path for full throughput.
  assign xfer      = or_vld & ((rb_cnt != 2'd2) | pop);
  assign in_ready  = ~or_vld | xfer;
  assign accept    = in_valid & in_ready;

  // The ALU flag only means overflow for arithmetic opcodes.
  assign wr_flag   = alu_flag & (or_op[3:2] == 2'b00);
  assign rb_wr_dat = {alu_result, wr_flag, or_tag};

  always_ff @(posedge clk) begin
    if (reset) begin
      or_vld <= 1'b0;
      or_a   <= '0;
      or_b   <= '0;
      or_op  <= '0;
      or_tag <= '0;
    end else if (accept) begin
      or_vld <= 1'b1;
      or_a   <= in_a;
      or_b   <= in_b;
      or_op  <= in_ALUop;
      or_tag <= in_tag;
    end else if (xfer) begin
      or_vld <= 1'b0;
    end
  end

  assign alu_a     = or_a;
  assign alu_b     = or_b;
  assign alu_ALUop = or_op;

  fifo #(
    .W     (RB_W),
    .DEPTH (2),
    .CW    (2)
  ) u_rb (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (xfer),
    .wr_dat (rb_wr_dat),
    .rd_rdy (pop),
    .rd_dat (rb_rd_dat),
    .count  (rb_cnt)
  );

  assign out_result = rb_rd_dat[RB_W-1 -: 32];
  assign out_flag   = rb_rd_dat[TAG_W];
  assign out_tag    = rb_rd_dat[TAG_W-1:0];

  // A new overflow in the same cycle as a clear keeps the bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_ovf <= 1'b0;
      op_count   <= '0;
    end else begin
      sticky_ovf <= (sticky_ovf & ~clr_sticky) | (xfer & wr_flag);
      if (xfer) begin
        op_count <= op_count + 16'd1;
      end
    end
  end
endmodule
